// File: rtl/demux_route_ctrl.sv
// rtl/demux_route_ctrl.sv - packet-locked select controller for a 1-to-2 demux with one-entry output register
// Optional per-output packet counters: define DEMUX_ROUTE_CTRL_STATS_EN.
module demux_route_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_last,
  output logic [1:0]        out_valid,
  input  logic [1:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              sel,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t            state, state_nx;
  logic              lock_sel;
  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic              last_r;
  logic              sel_r;
  logic              accept;
  logic              leave;
  logic              dest;

  // A held beat blocks input only while its own consumer is stalled.
  assign in_ready = !valid_r || out_ready[sel_r];
  assign accept   = in_valid && in_ready;
  assign leave    = valid_r && out_ready[sel_r];
  assign dest     = (state == IDLE) ? in_sel : lock_sel;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !in_last) state_nx = PKT;
      PKT:     if (accept && in_last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sel <= 1'b0;
      valid_r  <= 1'b0;
      data_r   <= '0;
      last_r   <= 1'b0;
      sel_r    <= 1'b0;
    end else begin
      if (accept && state == IDLE) lock_sel <= in_sel;
      if (accept) begin
        valid_r <= 1'b1;
        data_r  <= in_data;
        last_r  <= in_last;
        sel_r   <= dest;
      end else if (leave) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign out_valid = {valid_r && sel_r, valid_r && !sel_r};
  assign out_data  = data_r;
  assign out_last  = last_r;
  assign sel       = sel_r;
  assign busy      = (state == PKT) || valid_r;

`ifdef DEMUX_ROUTE_CTRL_STATS_EN
  logic [CNT_W-1:0] cnt0_r, cnt1_r;

  // A packet counts as complete when its last beat leaves; counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else if (leave && last_r) begin
      if (!sel_r && cnt0_r != {CNT_W{1'b1}}) cnt0_r <= cnt0_r + 1'b1;
      if (sel_r && cnt1_r != {CNT_W{1'b1}})  cnt1_r <= cnt1_r + 1'b1;
    end
  end

  assign pkt_cnt0 = cnt0_r;
  assign pkt_cnt1 = cnt1_r;
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// tb/tb_demux_route_ctrl.sv - self-checking bench for demux_route_ctrl
// Reference model: packet-level routing rules over a queue of held beats.
module tb_demux_route_ctrl;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_sel;
  logic          in_last;
  logic [1:0]    out_valid;
  logic [1:0]    out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          sel;
  logic          busy;
  logic [CW-1:0] pkt_cnt0;
  logic [CW-1:0] pkt_cnt1;

  demux_route_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .sel(sel), .busy(busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          dest;
  } beat_t;

  beat_t q[$];
  logic  m_in_pkt;
  logic  m_lock;
  logic  m_sel;
  int    m_cnt[2];
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_in_pkt = 1'b0;
    m_lock   = 1'b0;
    m_sel    = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic check_counters();
`ifdef DEMUX_ROUTE_CTRL_STATS_EN
    check("pkt_cnt0", 32'(pkt_cnt0), 32'(m_cnt[0]));
    check("pkt_cnt1", 32'(pkt_cnt1), 32'(m_cnt[1]));
`else
    check("pkt_cnt0", 32'(pkt_cnt0), 32'd0);
    check("pkt_cnt1", 32'(pkt_cnt1), 32'd0);
`endif
  endtask

  // Entered at a negedge; drives inputs, checks just before the posedge, updates the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic s,
                      input logic l, input logic [1:0] r);
    logic  exp_ready;
    logic  leave;
    logic  acc;
    logic  dst;
    beat_t b;
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_last   = l;
    out_ready = r;
    #4;
    exp_ready = (q.size() == 0) ? 1'b1 : r[q[0].dest];
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    if (q.size() == 0) begin
      check("out_valid", 32'(out_valid), 32'd0);
    end else begin
      check("out_valid", 32'(out_valid), q[0].dest ? 32'd2 : 32'd1);
      check("out_data", 32'(out_data), 32'(q[0].data));
      check("out_last", 32'(out_last), 32'(q[0].last));
    end
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_in_pkt || q.size() != 0));
    check_counters();
    leave = (q.size() != 0) && r[q[0].dest];
    acc   = v && exp_ready;
    @(posedge clk);
    if (leave) begin
      b = q.pop_front();
      if (b.last && m_cnt[b.dest] < (1 << CW) - 1) m_cnt[b.dest]++;
    end
    if (acc) begin
      dst = m_in_pkt ? m_lock : s;
      if (!m_in_pkt) m_lock = s;
      b.data = d;
      b.last = l;
      b.dest = dst;
      q.push_back(b);
      m_in_pkt = !l;
      m_sel    = dst;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_sel = 1'b0; in_last = 1'b0; out_ready = 2'b00;
    model_reset();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-stream: open a packet, hold a beat, then assert reset asynchronously.
    step(1'b1, 8'h5A, 1'b1, 1'b0, 2'b00);
    step(1'b1, 8'h5B, 1'b0, 1'b0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_last", 32'(out_last), 32'd0);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cnt0", 32'(pkt_cnt0), 32'd0);
    check("arst_cnt1", 32'(pkt_cnt1), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // 3-beat packet to output 1 with in_sel toggling after the first beat.
    step(1'b1, 8'hA0, 1'b1, 1'b0, 2'b11);
    step(1'b1, 8'hA1, 1'b0, 1'b0, 2'b11);
    step(1'b1, 8'hA2, 1'b1, 1'b1, 2'b11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    // Back-to-back single-beat packets alternating destinations.
    step(1'b1, 8'hB0, 1'b0, 1'b1, 2'b11);
    step(1'b1, 8'hB1, 1'b1, 1'b1, 2'b11);
    step(1'b1, 8'hB2, 1'b0, 1'b1, 2'b11);
    step(1'b1, 8'hB3, 1'b1, 1'b1, 2'b11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    // Stall on output 0 for 4 cycles with output-1 ready toggling.
    step(1'b1, 8'hC0, 1'b0, 1'b0, 2'b11);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hC1, 1'b1, 1'b0, (i % 2 == 0) ? 2'b10 : 2'b00);
      check("stall_data", 32'(out_data), 32'hC0);
    end
    step(1'b1, 8'hC1, 1'b1, 1'b0, 2'b01);
    step(1'b1, 8'hC2, 1'b1, 1'b1, 2'b01);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'b01);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'b01);

    // Five packets to output 1 to reach counter saturation.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, 2'b11);
      step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b1, 2'b11);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    // Randomized traffic with random backpressure and input gaps.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, 2'($urandom));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
